// File: rtl/spi_master_fifo.sv
// SPI mode-0 master with TX/RX first-word fall-through FIFOs.
// Optional: SPI_MASTER_LSB_FIRST_EN selects LSB-first shifting.
module spi_master_fifo #(
  parameter int TRANSFER_WIDTH = 8,
  parameter int TX_FIFO_DEPTH  = 16,
  parameter int RX_FIFO_DEPTH  = 16,
  parameter int CLK_DIV        = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             spi_sclk,
  output logic                             spi_mosi,
  input  logic                             spi_miso,
  output logic                             spi_cs_n,
  input  logic [TRANSFER_WIDTH-1:0]        tx_fifo_data,
  input  logic                             tx_fifo_valid,
  output logic                             tx_fifo_ready,
  output logic [$clog2(TX_FIFO_DEPTH):0]   tx_fifo_count,
  output logic [TRANSFER_WIDTH-1:0]        rx_fifo_data,
  output logic                             rx_fifo_valid,
  input  logic                             rx_fifo_ready,
  output logic [$clog2(RX_FIFO_DEPTH):0]   rx_fifo_count,
  output logic                             busy
);

  localparam int W   = TRANSFER_WIDTH;
  localparam int TAW = $clog2(TX_FIFO_DEPTH);
  localparam int RAW = $clog2(RX_FIFO_DEPTH);
  localparam int BW  = $clog2(W);
  localparam int DW  = $clog2(CLK_DIV + 1);

  localparam logic [TAW:0]  TX_FULL  = (TAW+1)'(TX_FIFO_DEPTH);
  localparam logic [RAW:0]  RX_FULL  = (RAW+1)'(RX_FIFO_DEPTH);
  localparam logic [RAW:0]  RX_LAST  = (RAW+1)'(RX_FIFO_DEPTH - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  logic [W-1:0]   tx_mem [TX_FIFO_DEPTH];
  logic [TAW-1:0] tx_wr;
  logic [TAW-1:0] tx_rd;
  logic [TAW:0]   tx_cnt;
  logic [W-1:0]   tx_head;
  logic           tx_push;
  logic           tx_pop;

  logic [W-1:0]   rx_mem [RX_FIFO_DEPTH];
  logic [RAW-1:0] rx_wr;
  logic [RAW-1:0] rx_rd;
  logic [RAW:0]   rx_cnt;
  logic           rx_push;
  logic           rx_pop;

  logic [1:0]     state;
  logic [DW-1:0]  div_cnt;
  logic [BW-1:0]  bit_cnt;
  logic [W-1:0]   tx_sh;
  logic [W-1:0]   rx_sh;

  logic           phase_end;
  logic           last_bit;
  logic           start_ok;
  logic           cont_ok;
  logic           head_bit;
  logic [W-1:0]   tx_next;
  logic           next_bit;
  logic [W-1:0]   rx_next;

  assign tx_head       = tx_mem[tx_rd];
  assign tx_fifo_ready = tx_cnt != TX_FULL;
  assign tx_fifo_count = tx_cnt;
  assign tx_push       = tx_fifo_valid && tx_fifo_ready;

  assign rx_fifo_data  = rx_mem[rx_rd];
  assign rx_fifo_valid = rx_cnt != '0;
  assign rx_fifo_count = rx_cnt;
  assign rx_pop        = rx_fifo_valid && rx_fifo_ready;

  assign busy      = state != ST_IDLE;
  assign phase_end = div_cnt == DIV_LAST;
  assign last_bit  = bit_cnt == BIT_LAST;

  // A new word may start only when its result is sure to fit in RX.
  assign start_ok = (tx_cnt != '0) && (rx_cnt != RX_FULL);
  // At word end the RX push is still pending, so one more slot is needed.
  assign cont_ok  = (tx_cnt != '0) && (rx_pop || (rx_cnt < RX_LAST));

  assign rx_push = (state == ST_LOW) && phase_end && last_bit;
  assign tx_pop  = ((state == ST_IDLE) && start_ok) ||
                   (rx_push && cont_ok);

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign head_bit = tx_head[0];
  assign tx_next  = {1'b0, tx_sh[W-1:1]};
  assign next_bit = tx_sh[1];
  assign rx_next  = {spi_miso, rx_sh[W-1:1]};
`else
  assign head_bit = tx_head[W-1];
  assign tx_next  = {tx_sh[W-2:0], 1'b0};
  assign next_bit = tx_sh[W-2];
  assign rx_next  = {rx_sh[W-2:0], spi_miso};
`endif

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= tx_fifo_data;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= rx_sh;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
    end
  end

  // Transfer sequencer: SETUP, then HIGH/LOW per bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state    <= ST_SETUP;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sh    <= tx_head;
            spi_mosi <= head_bit;
            spi_cs_n <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (phase_end) begin
            state    <= ST_HIGH;
            div_cnt  <= '0;
            spi_sclk <= 1'b1;
            rx_sh    <= rx_next;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_HIGH: begin
          if (phase_end) begin
            state    <= ST_LOW;
            div_cnt  <= '0;
            spi_sclk <= 1'b0;
            if (!last_bit) begin
              tx_sh    <= tx_next;
              spi_mosi <= next_bit;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_LOW: begin
          if (phase_end) begin
            div_cnt <= '0;
            if (last_bit) begin
              bit_cnt <= '0;
              if (cont_ok) begin
                state    <= ST_SETUP;
                tx_sh    <= tx_head;
                spi_mosi <= head_bit;
              end else begin
                state    <= ST_IDLE;
                spi_cs_n <= 1'b1;
                spi_mosi <= 1'b0;
              end
            end else begin
              state    <= ST_HIGH;
              bit_cnt  <= bit_cnt + 1'b1;
              spi_sclk <= 1'b1;
              rx_sh    <= rx_next;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// Bench for spi_master_fifo: MOSI->MISO loopback, queue model.
// Build with SPI_MASTER_LSB_FIRST_EN to check the LSB-first variant.
module tb_spi_master_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_cs_n;
  logic [7:0] tx_fifo_data = '0;
  logic       tx_fifo_valid = 1'b0;
  logic       tx_fifo_ready;
  logic [4:0] tx_fifo_count;
  logic [7:0] rx_fifo_data;
  logic       rx_fifo_valid;
  logic       rx_fifo_ready = 1'b0;
  logic [4:0] rx_fifo_count;
  logic       busy;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  int cs_low_cyc = 0;
  int sclk_rises = 0;
  int cs_rises = 0;
  logic [31:0] bits_sh = '0;
  logic sclk_q = 1'b0;
  logic cs_q = 1'b1;

  assign spi_miso = spi_mosi;

  always #5 clk = ~clk;

  spi_master_fifo #(
    .TRANSFER_WIDTH(8),
    .TX_FIFO_DEPTH(16),
    .RX_FIFO_DEPTH(16),
    .CLK_DIV(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n),
    .tx_fifo_data(tx_fifo_data),
    .tx_fifo_valid(tx_fifo_valid),
    .tx_fifo_ready(tx_fifo_ready),
    .tx_fifo_count(tx_fifo_count),
    .rx_fifo_data(rx_fifo_data),
    .rx_fifo_valid(rx_fifo_valid),
    .rx_fifo_ready(rx_fifo_ready),
    .rx_fifo_count(rx_fifo_count),
    .busy(busy)
  );

  // line activity observed mid-cycle
  always @(negedge clk) begin
    if (!spi_cs_n) cs_low_cyc++;
    if (spi_sclk && !sclk_q) begin
      sclk_rises++;
      bits_sh = {bits_sh[30:0], spi_mosi};
    end
    if (spi_cs_n && !cs_q) cs_rises++;
    sclk_q = spi_sclk;
    cs_q = spi_cs_n;
  end

  function automatic logic [7:0] wire_order(input logic [7:0] w);
    logic [7:0] r;
`ifdef SPI_MASTER_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tx_fifo_valid = 1'b0;
    rx_fifo_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int k = 0; k < 3000 && !tx_fifo_ready; k++) @(negedge clk);
    if (!tx_fifo_ready) begin
      total++;
      bad++;
      $display("FAIL push_wait: tx_fifo_ready=%b required 1", tx_fifo_ready);
    end
    tx_fifo_valid = 1'b1;
    tx_fifo_data = w;
    exp_q.push_back(w);
    @(negedge clk);
    tx_fifo_valid = 1'b0;
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    for (int k = 0; k < 3000 && !rx_fifo_valid; k++) @(negedge clk);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: model queue empty, rx_valid=%b", name, rx_fifo_valid);
    end else begin
      e = exp_q.pop_front();
      if (rx_fifo_valid !== 1'b1 || rx_fifo_data !== e) begin
        bad++;
        $display("FAIL %s: got %h (valid=%b) required %h",
                 name, rx_fifo_data, rx_fifo_valid, e);
      end
    end
    rx_fifo_ready = 1'b1;
    @(negedge clk);
    rx_fifo_ready = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 5000 && (busy || tx_fifo_count != 0); k++)
      @(negedge clk);
    total++;
    if (busy !== 1'b0 || tx_fifo_count !== 5'd0) begin
      bad++;
      $display("FAIL %s: busy=%b tx_count=%0d required 0/0",
               name, busy, tx_fifo_count);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (spi_cs_n !== 1'b1) begin bad++; $display("FAIL rst_cs_n: got %b required 1", spi_cs_n); end
    total++;
    if (spi_sclk !== 1'b0) begin bad++; $display("FAIL rst_sclk: got %b required 0", spi_sclk); end
    total++;
    if (spi_mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi: got %b required 0", spi_mosi); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
    total++;
    if (tx_fifo_count !== 5'd0 || rx_fifo_count !== 5'd0) begin
      bad++;
      $display("FAIL rst_counts: got %0d/%0d required 0/0", tx_fifo_count, rx_fifo_count);
    end
    total++;
    if (tx_fifo_ready !== 1'b1 || rx_fifo_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_flags: ready=%b valid=%b required 1/0", tx_fifo_ready, rx_fifo_valid);
    end
  endtask

  task automatic test_single();
    int c0, r0;
    c0 = cs_low_cyc;
    r0 = sclk_rises;
    push_word(8'hA5);
    wait_idle("single_idle");
    repeat (2) @(negedge clk);
    total++;
    if (cs_low_cyc - c0 !== 34) begin
      bad++;
      $display("FAIL single_cs_len: got %0d required 34", cs_low_cyc - c0);
    end
    total++;
    if (sclk_rises - r0 !== 8) begin
      bad++;
      $display("FAIL single_edges: got %0d required 8", sclk_rises - r0);
    end
    total++;
    if (bits_sh[7:0] !== wire_order(8'hA5)) begin
      bad++;
      $display("FAIL single_mosi: got %b required %b", bits_sh[7:0], wire_order(8'hA5));
    end
    pop_check("single_rx");
  endtask

  task automatic test_lsb_one();
    push_word(8'h01);
    wait_idle("one_idle");
    total++;
    if (bits_sh[7:0] !== wire_order(8'h01)) begin
      bad++;
      $display("FAIL one_mosi: got %b required %b", bits_sh[7:0], wire_order(8'h01));
    end
    pop_check("one_rx");
  endtask

  task automatic test_back_to_back();
    int c0, r0, h0;
    logic [23:0] e;
    c0 = cs_low_cyc;
    r0 = sclk_rises;
    h0 = cs_rises;
    push_word(8'h12);
    push_word(8'h34);
    push_word(8'h56);
    wait_idle("b2b_idle");
    repeat (2) @(negedge clk);
    e = {wire_order(8'h12), wire_order(8'h34), wire_order(8'h56)};
    total++;
    if (sclk_rises - r0 !== 24) begin
      bad++;
      $display("FAIL b2b_edges: got %0d required 24", sclk_rises - r0);
    end
    total++;
    if (cs_rises - h0 !== 1) begin
      bad++;
      $display("FAIL b2b_cs_gaps: got %0d cs releases required 1", cs_rises - h0);
    end
    total++;
    if (cs_low_cyc - c0 !== 102) begin
      bad++;
      $display("FAIL b2b_cs_len: got %0d required 102", cs_low_cyc - c0);
    end
    total++;
    if (bits_sh[23:0] !== e) begin
      bad++;
      $display("FAIL b2b_mosi: got %h required %h", bits_sh[23:0], e);
    end
    for (int i = 0; i < 3; i++) pop_check("b2b_rx");
  endtask

  task automatic test_random();
    int pushed;
    pushed = 0;
    for (int i = 0; i < 200 && (pushed < 24 || exp_q.size() != 0); i++) begin
      if (pushed < 24 && $urandom_range(0, 1) == 0) begin
        push_word(8'($urandom));
        pushed++;
      end else if (rx_fifo_valid) begin
        pop_check("rand_rx");
      end else begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
      end
    end
    while (exp_q.size() != 0) pop_check("rand_drain");
    wait_idle("rand_idle");
  endtask

  task automatic test_rx_full();
    apply_reset();
    for (int i = 0; i < 18; i++) push_word(8'($urandom));
    for (int k = 0; k < 3000 && (rx_fifo_count != 16 || busy); k++)
      @(negedge clk);
    total++;
    if (rx_fifo_count !== 5'd16 || busy !== 1'b0 || spi_cs_n !== 1'b1) begin
      bad++;
      $display("FAIL rxfull_stall: rx=%0d busy=%b cs_n=%b required 16/0/1",
               rx_fifo_count, busy, spi_cs_n);
    end
    repeat (10) @(negedge clk);
    total++;
    if (tx_fifo_count !== 5'd2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rxfull_hold: tx=%0d busy=%b required 2/0", tx_fifo_count, busy);
    end
    pop_check("rxfull_pop");
    for (int k = 0; k < 4 && !busy; k++) @(negedge clk);
    total++;
    if (busy !== 1'b1 || spi_cs_n !== 1'b0) begin
      bad++;
      $display("FAIL rxfull_resume: busy=%b cs_n=%b required 1/0", busy, spi_cs_n);
    end
    while (exp_q.size() != 0) pop_check("rxfull_drain");
  endtask

  task automatic test_tx_full();
    apply_reset();
    for (int i = 0; i < 16; i++) push_word(8'($urandom));
    for (int k = 0; k < 3000 && (rx_fifo_count != 16 || busy); k++)
      @(negedge clk);
    for (int i = 0; i < 16; i++) push_word(8'($urandom));
    total++;
    if (tx_fifo_ready !== 1'b0 || tx_fifo_count !== 5'd16) begin
      bad++;
      $display("FAIL txfull_flag: ready=%b count=%0d required 0/16",
               tx_fifo_ready, tx_fifo_count);
    end
    tx_fifo_valid = 1'b1;
    tx_fifo_data = 8'h77;
    @(negedge clk);
    tx_fifo_valid = 1'b0;
    total++;
    if (tx_fifo_count !== 5'd16 || rx_fifo_count !== 5'd16) begin
      bad++;
      $display("FAIL txfull_drop: tx=%0d rx=%0d required 16/16",
               tx_fifo_count, rx_fifo_count);
    end
    while (exp_q.size() != 0) pop_check("txfull_drain");
    wait_idle("txfull_idle");
    repeat (3) @(negedge clk);
    total++;
    if (rx_fifo_valid !== 1'b0) begin
      bad++;
      $display("FAIL txfull_extra: rx_valid=%b data=%h required empty", rx_fifo_valid, rx_fifo_data);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    apply_reset();
    r0 = sclk_rises;
    push_word(8'hC3);
    push_word(8'h5A);
    push_word(8'h0F);
    for (int k = 0; k < 2000 && (sclk_rises - r0 < 13); k++) @(negedge clk);
    total++;
    if (rx_fifo_count !== 5'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: rx=%0d busy=%b required 1/1", rx_fifo_count, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_abort: cs_n=%b sclk=%b busy=%b required 1/0/0",
               spi_cs_n, spi_sclk, busy);
    end
    total++;
    if (tx_fifo_count !== 5'd0 || rx_fifo_count !== 5'd0 || rx_fifo_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_flush: tx=%0d rx=%0d valid=%b required 0/0/0",
               tx_fifo_count, rx_fifo_count, rx_fifo_valid);
    end
    rst_n = 1'b1;
    exp_q.delete();
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b0 || spi_cs_n !== 1'b1) begin
      bad++;
      $display("FAIL mid_after: busy=%b cs_n=%b required 0/1", busy, spi_cs_n);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_lsb_one();
    test_back_to_back();
    test_random();
    test_rx_full();
    test_tx_full();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
